// File: rtl/divide_pkg.sv
// Shared widths and state encoding for the divide datapath.
// INWIDTH  : divisor / remainder width (also used by multiply)
// OUTWIDTH : dividend / quotient width and restoring iteration count
package divide_pkg;

    localparam int unsigned INWIDTH  = 8;
    localparam int unsigned OUTWIDTH = 2 * INWIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_t;

endpackage

// File: rtl/divide_step.sv
// One combinational restoring-division iteration.
// Ports:
//   rem      in  INWIDTH+1  partial remainder (always < dreg)
//   nq_msb   in  1          next dividend bit shifted into the remainder
//   dreg     in  INWIDTH    divisor
//   rem_next out INWIDTH+1  partial remainder after this step
//   qbit     out 1          quotient bit produced by this step
import divide_pkg::*;

module divide_step #(
    parameter int unsigned INWIDTH = divide_pkg::INWIDTH
) (
    input  logic [INWIDTH:0]   rem,
    input  logic               nq_msb,
    input  logic [INWIDTH-1:0] dreg,
    output logic [INWIDTH:0]   rem_next,
    output logic               qbit
);

    // Shift is computed one bit wider than t so the top remainder bit still
    // takes part in the compare; with rem < dreg that bit is always zero.
    logic [INWIDTH+1:0] t_w;
    logic [INWIDTH:0]   diff;

    always_comb begin
        t_w      = {rem, nq_msb};
        diff     = t_w[INWIDTH:0] - {1'b0, dreg};
        qbit     = (t_w >= {2'b00, dreg});
        rem_next = qbit ? diff : t_w[INWIDTH:0];
    end

endmodule

// File: rtl/divide.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk   in  1         rising-edge clock
//   rst   in  1         asynchronous active-high reset
//   start in  1         request, accepted on an edge while ready=1
//   N     in  OUTWIDTH  dividend, captured on accept
//   D     in  INWIDTH   divisor, captured on accept
//   Q     out OUTWIDTH  quotient (registered)
//   R     out INWIDTH   remainder (registered)
//   ready out 1         idle; Q/R/dbz hold a valid result
//   dbz   out 1         last result was a divide by zero
import divide_pkg::*;

module divide #(
    parameter int unsigned INWIDTH  = divide_pkg::INWIDTH,
    parameter int unsigned OUTWIDTH = 2 * INWIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OUTWIDTH-1:0] N,
    input  logic [INWIDTH-1:0]  D,
    output logic [OUTWIDTH-1:0] Q,
    output logic [INWIDTH-1:0]  R,
    output logic                ready,
    output logic                dbz
);

    localparam int unsigned CW = $clog2(OUTWIDTH + 1);

    div_state_t          state_q, state_d;
    logic [OUTWIDTH-1:0] nq_q, nq_d;
    logic [INWIDTH-1:0]  dreg_q, dreg_d;
    logic [INWIDTH:0]    rem_q, rem_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [OUTWIDTH-1:0] q_q, q_d;
    logic [INWIDTH-1:0]  r_q, r_d;
    logic                dbz_q, dbz_d;

    logic [INWIDTH:0]    rem_next;
    logic                qbit;

    divide_step #(
        .INWIDTH (INWIDTH)
    ) u_step (
        .rem      (rem_q),
        .nq_msb   (nq_q[OUTWIDTH-1]),
        .dreg     (dreg_q),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    always_comb begin
        state_d = state_q;
        nq_d    = nq_q;
        dreg_d  = dreg_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (D != '0) begin
                        nq_d    = N;
                        dreg_d  = D;
                        rem_d   = '0;
                        cnt_d   = CW'(OUTWIDTH);
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end else begin
                        // Divide by zero resolves in the accept cycle itself.
                        q_d   = '1;
                        r_d   = N[INWIDTH-1:0];
                        dbz_d = 1'b1;
                    end
                end
            end
            RUN: begin
                rem_d = rem_next;
                nq_d  = {nq_q[OUTWIDTH-2:0], qbit};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    q_d     = nq_d;
                    r_d     = rem_next[INWIDTH-1:0];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            nq_q    <= '0;
            dreg_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nq_q    <= nq_d;
            dreg_q  <= dreg_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign Q     = q_q;
    assign R     = r_q;
    assign dbz   = dbz_q;
    assign ready = (state_q == IDLE);

endmodule

// File: tb/tb_divide.sv
// Scoreboard bench for divide (INWIDTH=8, OUTWIDTH=16).
module tb_divide;

    localparam int unsigned IW = 8;
    localparam int unsigned OW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [OW-1:0] N = '0;
    logic [IW-1:0] D = '0;
    logic [OW-1:0] Q;
    logic [IW-1:0] R;
    logic          ready;
    logic          dbz;

    typedef struct packed {
        logic [OW-1:0] q;
        logic [IW-1:0] r;
        logic          dz;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    divide #(.INWIDTH(IW), .OUTWIDTH(OW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .N     (N),
        .D     (D),
        .Q     (Q),
        .R     (R),
        .ready (ready),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a result is presented either when ready rises or one edge
    // after a divide-by-zero accept.
    initial begin
        logic pr;
        logic z;
        int   low;
        exp_t e;
        pr  = 1'b1;
        low = 0;
        forever begin
            @(posedge clk);
            z = !rst && ready && start && (D == '0);
            @(negedge clk);
            if (rst) begin
                pr  = 1'b1;
                low = 0;
            end else begin
                if (!ready) low++;
                if (z || (!pr && ready)) begin
                    if (!z) chk("latency", low, OW);
                    low = 0;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result: got Q=%0h R=%0h expected none", Q, R);
                    end else begin
                        e = sb.pop_front();
                        chk("Q", Q, e.q);
                        chk("R", R, e.r);
                        chk("dbz", dbz, e.dz);
                    end
                end
                pr = ready;
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 expected 1");
        end
    endtask

    task automatic issue(input logic [OW-1:0] n, input logic [IW-1:0] d,
                         input logic [OW-1:0] eq, input logic [IW-1:0] er,
                         input logic edz);
        exp_t e;
        wait_ready();
        N     = n;
        D     = d;
        start = 1'b1;
        e.q = eq; e.r = er; e.dz = edz;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [OW-1:0] a, b;
        exp_t e;
        int k;

        repeat (2) @(negedge clk);
        chk("rst_Q", Q, 0);
        chk("rst_R", R, 0);
        chk("rst_dbz", dbz, 0);
        chk("rst_ready", ready, 1);
        #1 rst = 1'b0;
        @(negedge clk);

        // Basic and corner cases
        issue(16'd100, 8'd7, 16'd14, 8'd2, 1'b0);
        chk("run_ready_low", ready, 0);
        issue(16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0);
        issue(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0);
        issue(16'd5, 8'd200, 16'd0, 8'd5, 1'b0);
        issue(16'd0, 8'd5, 16'd0, 8'd0, 1'b0);
        issue(16'd1234, 8'd1, 16'd1234, 8'd0, 1'b0);

        // Divide by zero, then a valid op clears dbz
        issue(16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1);
        chk("dbz_ready_high", ready, 1);
        issue(16'd100, 8'd7, 16'd14, 8'd2, 1'b0);

        // Start while busy is ignored; outputs hold the previous result
        issue(16'd200, 8'd9, 16'd22, 8'd2, 1'b0);
        @(negedge clk);
        N = 16'd9; D = 8'd3; start = 1'b1;
        chk("busy_Q_hold", Q, 14);
        chk("busy_R_hold", R, 2);
        @(negedge clk);
        start = 1'b0;
        chk("busy_ready_low", ready, 0);
        wait_ready();

        // Async reset mid-run
        @(negedge clk);
        N = 16'd100; D = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrun_busy", ready, 0);
        #1 rst = 1'b1;
        #1;
        chk("async_ready", ready, 1);
        chk("async_Q", Q, 0);
        chk("async_R", R, 0);
        chk("async_dbz", dbz, 0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Back-to-back with start tied high
        a = 16'd10; b = 16'd1;
        N = 16'(a * b); D = b[IW-1:0]; start = 1'b1;
        e.q = a; e.r = '0; e.dz = 1'b0;
        sb.push_back(e);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_ready_one_cycle", ready, 0);
            wait_ready();
            if (i < 3) begin
                a = a + 16'd1;
                b = b + 16'd2;
                N = 16'(a * b);
                D = b[IW-1:0];
                e.q = a; e.r = '0; e.dz = 1'b0;
                sb.push_back(e);
            end else begin
                start = 1'b0;
            end
        end

        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("sb_drained", sb.size(), 0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
